// File: rtl/tcm_mem_pkg.sv
// Shared helpers for the parametrised tightly-coupled memory.
// Address range check, fetch alignment and stall LFSR constants.
package tcm_mem_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int fetch_bytes(input int words);
    return words * 4;
  endfunction

  function automatic logic [31:0] align_mask(input int bytes);
    return ~(32'(bytes) - 32'd1);
  endfunction

  // 33-bit compare so a window ending past 32'hFFFFFFFF never wraps
  function automatic logic in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          size_log2
  );
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'd1 << size_log2);
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/tcm_mem_param_resp_pipe.sv
// Fixed-latency response shift register with valid and payload.
// kill_i drops every entry already in flight; the new entry is kept.
module tcm_resp_pipe #(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         kill_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   dat [LAT];

  // shift valids/payloads; older entries cleared on kill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= valid_i;
      dat[0] <= valid_i ? data_i : '0;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1] & ~kill_i;
        dat[i] <= kill_i ? '0 : dat[i-1];
      end
    end
  end

  assign valid_o = vld[LAT-1];
  assign data_o  = dat[LAT-1];

endmodule

// File: rtl/tcm_mem_param.sv
// Dual-port TCM (fetch + data) with configurable base/size/latency.
// Optional accept stalling via LFSR under TCM_STALL_INJECT_EN.
module tcm_mem_param
  import tcm_mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE      = 32'h8000_0000,
  parameter int          MEM_SIZE_LOG2 = 17,
  parameter int          FETCH_WORDS   = 2,
  parameter int          RD_LATENCY    = 1,
  parameter int          TAG_W         = 11
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_i_rd_i,
  input  logic                    mem_i_flush_i,
  input  logic                    mem_i_invalidate_i,
  input  logic [31:0]             mem_i_pc_i,
  output logic                    mem_i_accept_o,
  output logic                    mem_i_valid_o,
  output logic                    mem_i_error_o,
  output logic [32*FETCH_WORDS-1:0] mem_i_inst_o,
  input  logic [31:0]             mem_d_addr_i,
  input  logic [31:0]             mem_d_data_wr_i,
  input  logic                    mem_d_rd_i,
  input  logic [3:0]              mem_d_wr_i,
  input  logic                    mem_d_cacheable_i,
  input  logic [TAG_W-1:0]        mem_d_req_tag_i,
  input  logic                    mem_d_invalidate_i,
  input  logic                    mem_d_writeback_i,
  input  logic                    mem_d_flush_i,
  output logic                    mem_d_accept_o,
  output logic                    mem_d_ack_o,
  output logic                    mem_d_error_o,
  output logic [31:0]             mem_d_data_rd_o,
  output logic [TAG_W-1:0]        mem_d_resp_tag_o
);

  localparam int WORDS       = 2 ** (MEM_SIZE_LOG2 - 2);
  localparam int IDX_W       = MEM_SIZE_LOG2 - 2;
  localparam int FETCH_BYTES = fetch_bytes(FETCH_WORDS);
  localparam int IW          = 1 + 32 * FETCH_WORDS;
  localparam int DW          = 1 + TAG_W + 32;

  logic [31:0] mem [WORDS];

  logic i_acc;
  logic d_acc;

`ifdef TCM_STALL_INJECT_EN
  logic [15:0] lfsr;

  // stall pattern advances every non-reset cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign i_acc = ~rst_i & (lfsr[1:0] != 2'b00);
  assign d_acc = ~rst_i & (lfsr[3:2] != 2'b00);
`else
  assign i_acc = ~rst_i;
  assign d_acc = ~rst_i;
`endif

  assign mem_i_accept_o = i_acc;
  assign mem_d_accept_o = d_acc;

  logic unused;
  assign unused = ^{mem_d_cacheable_i, mem_i_invalidate_i};

  logic [31:0]              i_pc_al;
  logic                     i_ok;
  logic                     i_take;
  logic [IDX_W-1:0]         i_idx;
  logic [32*FETCH_WORDS-1:0] i_blk;

  assign i_pc_al = mem_i_pc_i & align_mask(FETCH_BYTES);
  assign i_ok    = in_range(i_pc_al, MEM_BASE, MEM_SIZE_LOG2);
  assign i_idx   = IDX_W'((i_pc_al - MEM_BASE) >> 2);
  assign i_take  = mem_i_rd_i & i_acc;

  // gather the aligned fetch block, lane 0 at the lowest word
  always_comb begin
    i_blk = '0;
    if (i_ok) begin
      for (int k = 0; k < FETCH_WORDS; k++) begin
        i_blk[32*k +: 32] = mem[i_idx | IDX_W'(k)];
      end
    end
  end

  logic             d_access;
  logic             d_req;
  logic             d_take;
  logic             d_ok;
  logic             d_err;
  logic             d_we;
  logic [IDX_W-1:0] d_idx;
  logic [31:0]      d_word;
  logic [31:0]      d_rdata;
  logic [31:0]      d_merge;

  assign d_access = mem_d_rd_i | (|mem_d_wr_i);
  assign d_req    = d_access | mem_d_invalidate_i
                  | mem_d_writeback_i | mem_d_flush_i;
  assign d_take   = d_req & d_acc;
  assign d_ok     = in_range(mem_d_addr_i, MEM_BASE, MEM_SIZE_LOG2);
  assign d_err    = d_access & ~d_ok;
  assign d_idx    = IDX_W'((mem_d_addr_i - MEM_BASE) >> 2);
  assign d_word   = mem[d_idx];
  assign d_rdata  = (mem_d_rd_i & d_ok) ? d_word : 32'd0;
  assign d_we     = d_take & (|mem_d_wr_i) & d_ok;

  // byte-strobe merge of write data onto the current word
  always_comb begin
    d_merge = d_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_d_wr_i[b]) begin
        d_merge[8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
      end
    end
  end

  // storage write; plain always so the loader task may also write it
  always @(posedge clk_i) begin
    if (d_we) begin
      mem[d_idx] <= d_merge;
    end
  end

  logic          i_vld;
  logic [IW-1:0] i_pay;
  logic          d_vld;
  logic [DW-1:0] d_pay;

  tcm_resp_pipe #(
    .LAT (RD_LATENCY),
    .W   (IW)
  ) u_i_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .kill_i  (mem_i_flush_i),
    .valid_i (i_take),
    .data_i  ({~i_ok, i_blk}),
    .valid_o (i_vld),
    .data_o  (i_pay)
  );

  tcm_resp_pipe #(
    .LAT (RD_LATENCY),
    .W   (DW)
  ) u_d_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .kill_i  (1'b0),
    .valid_i (d_take),
    .data_i  ({d_err, mem_d_req_tag_i, d_rdata}),
    .valid_o (d_vld),
    .data_o  (d_pay)
  );

  assign mem_i_valid_o = i_vld;
  assign {mem_i_error_o, mem_i_inst_o} = i_pay;

  assign mem_d_ack_o = d_vld;
  assign {mem_d_error_o, mem_d_resp_tag_o, mem_d_data_rd_o} = d_pay;

  // zero-time byte loader for benches
  task automatic write(
    input logic [31:0] byte_offset,
    input logic [7:0]  value
  );
    mem[IDX_W'(byte_offset >> 2)][8*byte_offset[1:0] +: 8] <= value;
  endtask

endmodule
